// File: rtl/game_sequencer_if.sv
// game_sequencer_if: groups the game-flow inputs (collision/frame/start)
// and the registered game-state outputs of game_sequencer into one bundle.
// slave = the sequencer itself, master = whatever drives it.
interface game_sequencer_if #(
  parameter int LIVES_W      = 2,
  parameter int SCORE_W      = 7,
  parameter int HIT_CH       = 6,
  parameter int NUM_INVADERS = 55,
  parameter int WAVE_W       = 4
);
  logic                    arst_i;
  logic                    frame_i;
  logic                    start_i;
  logic [HIT_CH-1:0]       invader_hit_i;
  logic                    player_hit_i;
  logic                    landed_i;
  logic [NUM_INVADERS-1:0] invaders_i;
  logic [2:0]              state_o;
  logic                    freeze_o;
  logic                    wave_start_o;
  logic [LIVES_W-1:0]      lives_o;
  logic [SCORE_W-1:0]      score_o;
  logic [WAVE_W-1:0]       wave_o;
  logic [SCORE_W-1:0]      high_score_o;

  modport slave (
    input  arst_i, frame_i, start_i, invader_hit_i, player_hit_i, landed_i, invaders_i,
    output state_o, freeze_o, wave_start_o, lives_o, score_o, wave_o, high_score_o
  );

  modport master (
    output arst_i, frame_i, start_i, invader_hit_i, player_hit_i, landed_i, invaders_i,
    input  state_o, freeze_o, wave_start_o, lives_o, score_o, wave_o, high_score_o
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller (attract / play / respawn /
// wave-clear / game-over) owning lives, saturating score, wave number and
// frame-timed delays. All outputs are registered.
// Optional macro HIGH_SCORE_EN: keeps a best-score register that survives
// the soft restart (arst); without it high_score is constant 0.
module game_sequencer #(
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_W        = 2,
  parameter int SCORE_W        = 7,
  parameter int KILL_PTS       = 1,
  parameter int CLEAR_BONUS    = 5,
  parameter int HIT_CH         = 6,
  parameter int NUM_INVADERS   = 55,
  parameter int WAVE_W         = 4,
  parameter int RESPAWN_FRAMES = 60,
  parameter int CLEAR_FRAMES   = 120
) (
  input logic             clk,
  input logic             rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_PLAY       = 3'd1,
    ST_RESPAWN    = 3'd2,
    ST_WAVE_CLEAR = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam int MAX_FRAMES = (RESPAWN_FRAMES > CLEAR_FRAMES) ? RESPAWN_FRAMES : CLEAR_FRAMES;
  localparam int TIMER_W    = $clog2(MAX_FRAMES + 1);
  localparam int CNT_W      = $clog2(HIT_CH + 1);
  // Wide enough for max score plus a full kill burst plus the clear bonus.
  localparam int SUM_W      = SCORE_W + $clog2(HIT_CH * KILL_PTS + CLEAR_BONUS + 1) + 1;
  localparam logic [SUM_W-1:0] SCORE_SAT = {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [WAVE_W-1:0]  wave_q, wave_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               wave_start_q, wave_start_d;
  logic               freeze_q, freeze_d;
  logic               start_prev_q;

  logic               start_edge;
  logic [CNT_W-1:0]   hit_cnt;
  logic [SUM_W-1:0]   kill_sum, bonus_sum;
  logic [SCORE_W-1:0] score_kill, score_bonus;

  assign start_edge = bus.start_i & ~start_prev_q;

  // Saturating score arithmetic: kill points first, clear bonus on top.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < HIT_CH; i++) begin
      hit_cnt = hit_cnt + CNT_W'(bus.invader_hit_i[i]);
    end
    kill_sum    = SUM_W'(score_q) + SUM_W'(hit_cnt) * SUM_W'(KILL_PTS);
    score_kill  = (kill_sum > SCORE_SAT) ? SCORE_SAT[SCORE_W-1:0] : kill_sum[SCORE_W-1:0];
    bonus_sum   = SUM_W'(score_kill) + SUM_W'(CLEAR_BONUS);
    score_bonus = (bonus_sum > SCORE_SAT) ? SCORE_SAT[SCORE_W-1:0] : bonus_sum[SCORE_W-1:0];
  end

  // Next-state and next-output logic for the game-flow FSM.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    score_d      = score_q;
    wave_d       = wave_q;
    timer_d      = timer_q;
    wave_start_d = 1'b0;
    case (state_q)
      ST_ATTRACT, ST_GAME_OVER: begin
        if (start_edge) begin
          lives_d      = LIVES_W'(LIVES_INIT);
          score_d      = '0;
          wave_d       = WAVE_W'(1);
          wave_start_d = 1'b1;
          state_d      = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Kill points are banked even when a transition fires this cycle.
        score_d = score_kill;
        if (bus.landed_i) begin
          lives_d = '0;
          state_d = ST_GAME_OVER;
        end else if (bus.player_hit_i && (lives_q <= LIVES_W'(1))) begin
          lives_d = '0;
          state_d = ST_GAME_OVER;
        end else if (bus.player_hit_i) begin
          lives_d = lives_q - LIVES_W'(1);
          timer_d = '0;
          state_d = ST_RESPAWN;
        end else if (bus.invaders_i == '0) begin
          score_d = score_bonus;
          timer_d = '0;
          state_d = ST_WAVE_CLEAR;
        end
      end
      ST_RESPAWN: begin
        // A held player_hit is masked here, so it costs a single life.
        if (bus.frame_i) begin
          if (timer_q == TIMER_W'(RESPAWN_FRAMES - 1)) state_d = ST_PLAY;
          else timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_WAVE_CLEAR: begin
        if (bus.frame_i) begin
          if (timer_q == TIMER_W'(CLEAR_FRAMES - 1)) begin
            wave_d       = (wave_q == '1) ? wave_q : wave_q + WAVE_W'(1);
            wave_start_d = 1'b1;
            state_d      = ST_PLAY;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      default: state_d = ST_ATTRACT;
    endcase
    freeze_d = (state_d != ST_PLAY);
  end

  // State and output registers; arst is a synchronous soft restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ATTRACT;
      lives_q      <= LIVES_W'(LIVES_INIT);
      score_q      <= '0;
      wave_q       <= '0;
      timer_q      <= '0;
      wave_start_q <= 1'b0;
      freeze_q     <= 1'b1;
    end else if (bus.arst_i) begin
      state_q      <= ST_ATTRACT;
      lives_q      <= LIVES_W'(LIVES_INIT);
      score_q      <= '0;
      wave_q       <= '0;
      timer_q      <= '0;
      wave_start_q <= 1'b0;
      freeze_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      wave_q       <= wave_d;
      timer_q      <= timer_d;
      wave_start_q <= wave_start_d;
      freeze_q     <= freeze_d;
    end
  end

  // Start history keeps tracking through arst so a held button cannot retrigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_prev_q <= 1'b0;
    else     start_prev_q <= bus.start_i;
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score_q, high_score_d;

  // Capture the final score (kills included) on the cycle a game ends.
  always_comb begin
    high_score_d = high_score_q;
    if (!bus.arst_i && (state_q == ST_PLAY) && (state_d == ST_GAME_OVER) &&
        (score_d > high_score_q)) begin
      high_score_d = score_d;
    end
  end

  // Best score survives arst; only the hard reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) high_score_q <= '0;
    else     high_score_q <= high_score_d;
  end

  assign bus.high_score_o = high_score_q;
`else
  assign bus.high_score_o = '0;
`endif

  assign bus.state_o      = state_q;
  assign bus.freeze_o     = freeze_q;
  assign bus.wave_start_o = wave_start_q;
  assign bus.lives_o      = lives_q;
  assign bus.score_o      = score_q;
  assign bus.wave_o       = wave_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scenario tasks drive the sequencer, push expected
// output snapshots into a scoreboard queue and compare them against the
// sampled DUT outputs. Build with +define+HIGH_SCORE_EN to cover high_score.
module tb_game_sequencer;

  // Snapshot layout: state(3) freeze(1) wave_start(1) lives(2) score(7) wave(4) high_score(7)
  typedef logic [24:0] snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_sequencer_if bus ();

  game_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  int    vectors     = 0;
  int    miscompares = 0;
  int    hs_exp      = 0;
  snap_t exp_q[$];
  snap_t obs_q[$];
  string tag_q[$];

  // Expected snapshot; freeze is high in every state except PLAY.
  function automatic snap_t mk(input int st, input int ws, input int lv, input int sc, input int wv);
    logic [2:0] s3;
    s3 = 3'(st);
    return {s3, (s3 != 3'd1), 1'(ws), 2'(lv), 7'(sc), 4'(wv), 7'(hs_exp)};
  endfunction

  function automatic snap_t obs();
    return {bus.state_o, bus.freeze_o, bus.wave_start_o, bus.lives_o,
            bus.score_o, bus.wave_o, bus.high_score_o};
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d fr=%0d ws=%0d lv=%0d sc=%0d wv=%0d hs=%0d",
                     s[24:22], s[21], s[20], s[19:18], s[17:11], s[10:7], s[6:0]);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input snap_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    obs_q.push_back(obs());
  endtask

  // One clock with an expectation registered before the edge.
  task automatic cyc(input string tag, input snap_t e);
    push_exp(tag, e);
    tick(1);
    sample();
  endtask

  // n frame pulses, one every 4 clocks.
  task automatic frames(input int n);
    repeat (n) begin
      bus.frame_i = 1'b1;
      tick(1);
      bus.frame_i = 1'b0;
      tick(3);
    end
  endtask

  task automatic test_reset();
    snap_t e, o;
    string t;
    rst = 1'b1;
    bus.arst_i = 1'b0; bus.frame_i = 1'b0; bus.start_i = 1'b0;
    bus.invader_hit_i = '0; bus.player_hit_i = 1'b0; bus.landed_i = 1'b0;
    bus.invaders_i = '1;
    tick(2);
    push_exp("reset_held", mk(0, 0, 3, 0, 0));
    sample();
    rst = 1'b0;
    cyc("reset_idle", mk(0, 0, 3, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  task automatic test_start();
    snap_t e, o;
    string t;
    bus.start_i = 1'b1;
    cyc("start_edge", mk(1, 1, 3, 0, 1));
    cyc("start_held_no_pulse", mk(1, 0, 3, 0, 1));
    tick(3);
    push_exp("start_held_later", mk(1, 0, 3, 0, 1));
    sample();
    bus.start_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o;
    string t;
    bus.invader_hit_i = '1;
    cyc("kill_6", mk(1, 0, 3, 6, 1));
    cyc("kill_12", mk(1, 0, 3, 12, 1));
    bus.invader_hit_i = '0;
    hs_exp = 0;
    #3;
    push_exp("async_rst_mid_play", mk(0, 0, 3, 0, 0));
    rst = 1'b1;
    #1;
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("after_rst_release", mk(0, 0, 3, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  task automatic test_kill_respawn();
    snap_t e, o;
    string t;
    bus.start_i = 1'b1;
    cyc("restart", mk(1, 1, 3, 0, 1));
    bus.start_i = 1'b0;
    bus.invader_hit_i = 6'b000101;
    cyc("two_kills", mk(1, 0, 3, 2, 1));
    bus.invader_hit_i = '0;
    bus.player_hit_i = 1'b1;
    cyc("hit_to_respawn", mk(2, 0, 2, 2, 1));
    tick(9);
    push_exp("hit_held_one_life", mk(2, 0, 2, 2, 1));
    sample();
    bus.player_hit_i = 1'b0;
    bus.invader_hit_i = 6'b000001;   // must be ignored while respawning
    frames(59);
    push_exp("respawn_59_frames", mk(2, 0, 2, 2, 1));
    sample();
    bus.invader_hit_i = '0;
    bus.frame_i = 1'b1;
    cyc("respawn_exit_60", mk(1, 0, 2, 2, 1));
    bus.frame_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  task automatic test_wave_clear();
    snap_t e, o;
    string t;
    bus.invader_hit_i = '1;
    tick(19);
    cyc("kills_to_122", mk(1, 0, 2, 122, 1));
    bus.invader_hit_i = 6'b000011;
    cyc("score_124", mk(1, 0, 2, 124, 1));
    bus.invader_hit_i = 6'b000001;
    bus.invaders_i = '0;
    cyc("clear_bonus_saturates", mk(3, 0, 2, 127, 1));
    bus.invader_hit_i = '0;
    bus.invaders_i = '1;
    frames(119);
    push_exp("clear_119_frames", mk(3, 0, 2, 127, 1));
    sample();
    bus.frame_i = 1'b1;
    cyc("clear_exit_wave2", mk(1, 1, 2, 127, 2));
    bus.frame_i = 1'b0;
    cyc("clear_pulse_one_cycle", mk(1, 0, 2, 127, 2));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  task automatic test_landed();
    snap_t e, o;
    string t;
    bus.landed_i = 1'b1;
    bus.player_hit_i = 1'b1;
    hs_exp = HS_EN ? 127 : 0;
    cyc("landed_game_over", mk(4, 0, 0, 127, 2));
    bus.landed_i = 1'b0;
    bus.player_hit_i = 1'b0;
    tick(5);
    push_exp("game_over_holds", mk(4, 0, 0, 127, 2));
    sample();
    bus.start_i = 1'b1;
    cyc("game_over_restart", mk(1, 1, 3, 0, 1));
    bus.start_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  task automatic test_high_score();
    snap_t e, o;
    string t;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hs_exp = 0;
    tick(1);
    bus.start_i = 1'b1;
    cyc("game1_start", mk(1, 1, 3, 0, 1));
    bus.start_i = 1'b0;
    bus.invader_hit_i = '1;
    tick(6);
    bus.invader_hit_i = 6'b001111;
    cyc("game1_score_40", mk(1, 0, 3, 40, 1));
    bus.invader_hit_i = '0;
    bus.landed_i = 1'b1;
    hs_exp = HS_EN ? 40 : 0;
    cyc("game1_over", mk(4, 0, 0, 40, 1));
    bus.landed_i = 1'b0;
    bus.start_i = 1'b1;
    cyc("game2_start", mk(1, 1, 3, 0, 1));
    bus.start_i = 1'b0;
    bus.invader_hit_i = '1;
    tick(4);
    bus.invader_hit_i = 6'b000001;
    bus.landed_i = 1'b1;
    cyc("game2_over_25", mk(4, 0, 0, 25, 1));
    bus.invader_hit_i = '0;
    bus.landed_i = 1'b0;
    bus.arst_i = 1'b1;
    cyc("arst_keeps_high", mk(0, 0, 3, 0, 0));
    bus.arst_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  task automatic test_last_life();
    snap_t e, o;
    string t;
    bus.start_i = 1'b1;
    cyc("game3_start", mk(1, 1, 3, 0, 1));
    bus.start_i = 1'b0;
    bus.player_hit_i = 1'b1;
    cyc("lives_3_to_2", mk(2, 0, 2, 0, 1));
    bus.player_hit_i = 1'b0;
    frames(60);
    push_exp("back_in_play", mk(1, 0, 2, 0, 1));
    sample();
    bus.player_hit_i = 1'b1;
    cyc("lives_2_to_1", mk(2, 0, 1, 0, 1));
    bus.player_hit_i = 1'b0;
    frames(60);
    bus.player_hit_i = 1'b1;
    cyc("last_life_game_over", mk(4, 0, 0, 0, 1));
    bus.player_hit_i = 1'b0;
    tick(2);
    push_exp("lives_stay_zero", mk(4, 0, 0, 0, 1));
    sample();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s: got %s, need %s", t, fmt(o), fmt(e)); end
      else $display("pass %s: %s", t, fmt(o));
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_async_reset();
    test_kill_respawn();
    test_wave_clear();
    test_landed();
    test_high_score();
    test_last_life();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Parametrised game-flow controller that owns lives, score, wave number and round sequencing. It sits between the collision outputs of vga_controller and the sprite/projectile blocks. It replaces the fixed-function score_logic with a full state machine: attract, play, respawn, wave-clear and game-over. It runs in the clk_pixel domain and times all delays in frame pulses.

Parameters:
LIVES_INIT, 3, lives loaded at game start
LIVES_W, 2, width of lives counter
SCORE_W, 7, width of score (saturating)
KILL_PTS, 1, points per invader hit
CLEAR_BONUS, 5, points added on wave clear
HIT_CH, 6, number of invader_hit channels
NUM_INVADERS, 55, width of invaders alive vector
WAVE_W, 4, width of wave counter (saturating)
RESPAWN_FRAMES, 60, frames spent in RESPAWN
CLEAR_FRAMES, 120, frames spent in WAVE_CLEAR

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
arst  in  1  synchronous soft restart (debounced button level)
frame  in  1  one-cycle pulse per video frame
start  in  1  debounced shoot level, used as start request
invader_hit  in  HIT_CH  one bit per laser/invader collision this cycle
player_hit  in  1  player struck by any missile
landed  in  1  invader formation reached player row
invaders  in  NUM_INVADERS  alive mask, 1 = alive
state  out  3  current state encoding
freeze  out  1  1 = sprite/projectile blocks hold position
wave_start  out  1  one-cycle pulse when a wave (re)starts
lives  out  LIVES_W  remaining lives
score  out  SCORE_W  current score
wave  out  WAVE_W  current wave number
high_score  out  SCORE_W  best score (see optional feature)

Behaviour:
- Reset (rst async, or arst sampled high on a clk edge) produces:
  - state=ATTRACT(0), freeze=1, wave_start=0.
  - lives=LIVES_INIT, score=0, wave=0, internal frame timer=0.
  - high_score is not cleared by arst. It is cleared only by rst.
- States: ATTRACT=0, PLAY=1, RESPAWN=2, WAVE_CLEAR=3, GAME_OVER=4. freeze=1 in every state except PLAY.
- start detection: rising edge of start. A level held high across a transition does not retrigger.
- ATTRACT/GAME_OVER, on start edge, in one cycle:
  - lives=LIVES_INIT, score=0, wave=1.
  - Assert wave_start for one cycle; next state is PLAY.
- PLAY, each cycle, evaluated in this priority order:
  1. Score update. score += popcount(invader_hit)*KILL_PTS. Width-extended sum, saturates at 2^SCORE_W-1. Always applied, even if a transition fires the same cycle.
  2. landed=1: lives=0, go to GAME_OVER.
  3. player_hit=1 and lives==1: lives=0, go to GAME_OVER.
  4. player_hit=1 and lives>1: lives-=1, timer=0, go to RESPAWN.
  5. invaders==0: score += CLEAR_BONUS (saturating, after the kill add), timer=0, go to WAVE_CLEAR.
- RESPAWN:
  - timer increments on frame.
  - When timer==RESPAWN_FRAMES-1 and frame=1, go to PLAY. No wave_start pulse.
  - Inputs other than arst are ignored.
- WAVE_CLEAR:
  - Same timing rule with CLEAR_FRAMES.
  - On exit: wave+=1 (saturates at 2^WAVE_W-1), wave_start pulses one cycle, go to PLAY.
- GAME_OVER: outputs hold until a start edge.
- player_hit held high across several cycles costs one life only. The respawn state masks it.
- lives never decrements below 0.
- All outputs are registered, with one-cycle latency from input to output.

Optional Feature:
HIGH_SCORE_EN
- Defined:
  - On entry to GAME_OVER, high_score <= max(high_score, score), using the final score including any same-cycle kill points.
  - Persists across arst.
- Undefined: high_score is tied to 0 and no register is inferred.

Test Plan:
1. Assert rst mid-PLAY with score=12 -> outputs return asynchronously to state=0, lives=3, score=0, wave=0, freeze=1.
2. From ATTRACT, start edge -> next cycle state=1, wave=1, wave_start high exactly one cycle. Holding start high afterwards causes no second pulse.
3. In PLAY, invader_hit=6'b000101 for one cycle, then player_hit held 10 cycles with lives=3 -> score+=2, lives=2, state=2. With frame every 4 clks, state=1 after 60 frames.
4. In PLAY with score=124, invaders go to 0 with invader_hit=6'b000001 the same cycle -> score=125 then saturates to 127, state=3. After 120 frames: wave=2, wave_start pulse, state=1.
5. In PLAY with lives=2, landed and player_hit asserted the same cycle -> lives=0, state=4. A later start edge gives lives=3, score=0, wave=1.
6. With HIGH_SCORE_EN, two games ending at score 40 then 25, then arst -> high_score=40. Without the macro, high_score=0 throughout.
